// File: rtl/as_oq_port_demux.sv
// as_oq_port_demux: buffers pipeline words in a small input FIFO, decodes the
// one-hot dst-port field of the IOQ module header and replicates each packet to
// every selected output lane. Packets with no selected lane or no IOQ header
// are dropped. Forwarded and dropped packets are counted.
module as_oq_port_demux #(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int unsigned NUM_OUTPUT_QUEUES  = 8,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] PORT_MASK = {NUM_OUTPUT_QUEUES{1'b1}},
  parameter int unsigned IN_FIFO_DEPTH_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
  output logic [31:0]                  pkt_fwd_cnt,
  output logic [31:0]                  pkt_drop_cnt
);

  localparam int unsigned DST_POS = 16;
  localparam int unsigned DEPTH   = 1 << IN_FIFO_DEPTH_BITS;
  localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(8'hFF);
  localparam logic [IN_FIFO_DEPTH_BITS:0] CNT_FULL  = (IN_FIFO_DEPTH_BITS+1)'(DEPTH);
  localparam logic [IN_FIFO_DEPTH_BITS:0] CNT_NFULL = (IN_FIFO_DEPTH_BITS+1)'(DEPTH - 1);

  typedef enum logic [3:0] {
    WAIT_SOP = 4'b0001,
    FWD_HDRS = 4'b0010,
    FWD_DATA = 4'b0100,
    DROP     = 4'b1000
  } state_e;

  // Input FIFO storage and pointers
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_q [DEPTH];
  logic [IN_FIFO_DEPTH_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IN_FIFO_DEPTH_BITS:0]      count_q, count_d;
  logic                             fifo_empty, push, pop;
  logic [DATA_WIDTH-1:0]            head_data;
  logic [CTRL_WIDTH-1:0]            head_ctrl;

  // Control state
  state_e                         state_q, state_d;
  logic [NUM_OUTPUT_QUEUES-1:0]   dst_lat_q, dst_lat_d;
  logic                           drop_in_data_q, drop_in_data_d;
  logic [31:0]                    fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [NUM_OUTPUT_QUEUES-1:0]   sop_dst, eff_dst;
  logic                           fire;

  assign fifo_empty = (count_q == '0);
  assign push       = in_wr && (count_q != CNT_FULL);
  assign in_rdy     = !(count_q >= CNT_NFULL);
  assign {head_data, head_ctrl} = mem_q[rd_ptr_q];

  assign out_data     = head_data;
  assign out_ctrl     = head_ctrl;
  assign pkt_fwd_cnt  = fwd_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;

  // In WAIT_SOP the lane set is taken straight from the head so the first word
  // can fire in the same cycle it is examined (no bubble between packets).
  assign sop_dst = (head_ctrl == IOQ_CTRL) ? (head_data[DST_POS +: NUM_OUTPUT_QUEUES] & PORT_MASK) : '0;
  assign eff_dst = (state_q == WAIT_SOP) ? sop_dst : dst_lat_q;
  assign fire    = !fifo_empty && (state_q != DROP) && (&(out_rdy | ~eff_dst));
  assign out_wr  = reset ? (eff_dst & {NUM_OUTPUT_QUEUES{fire}}) : '0;

  // Write-only storage; flushing is done by resetting the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_ctrl};
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Packet FSM: next state, lane latch, pop decision and counters
  always_comb begin
    state_d        = state_q;
    dst_lat_d      = dst_lat_q;
    drop_in_data_d = drop_in_data_q;
    fwd_cnt_d      = fwd_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    pop            = 1'b0;
    unique case (state_q)
      WAIT_SOP: begin
        if (!fifo_empty) begin
          if (sop_dst != '0) begin
            dst_lat_d = sop_dst;
            if (fire) begin
              pop     = 1'b1;
              state_d = FWD_HDRS;
            end
          end else begin
            pop            = 1'b1;
            state_d        = DROP;
            drop_in_data_d = (head_ctrl == '0);
          end
        end
      end
      FWD_HDRS: begin
        if (fire) begin
          pop = 1'b1;
          if (head_ctrl == '0) state_d = FWD_DATA;
        end
      end
      FWD_DATA: begin
        if (fire) begin
          pop = 1'b1;
          if (head_ctrl != '0) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
            state_d   = WAIT_SOP;
          end
        end
      end
      DROP: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_ctrl == '0) begin
            drop_in_data_d = 1'b1;
          end else if (drop_in_data_q) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = WAIT_SOP;
          end
        end
      end
      default: state_d = WAIT_SOP;
    endcase
  end

  // State, FIFO pointers and counters with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= WAIT_SOP;
      dst_lat_q      <= '0;
      drop_in_data_q <= 1'b0;
      fwd_cnt_q      <= '0;
      drop_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      dst_lat_q      <= dst_lat_d;
      drop_in_data_q <= drop_in_data_d;
      fwd_cnt_q      <= fwd_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_as_oq_port_demux.sv
// tb_as_oq_port_demux: drives two demux instances (full mask and 8'h55 mask)
// with the same packet stream and checks lanes, data, counters and timing.
module tb_as_oq_port_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic [7:0]  out_rdy;

  logic        in_rdy_a, in_rdy_b;
  logic [63:0] out_data_a, out_data_b;
  logic [7:0]  out_ctrl_a, out_ctrl_b, out_wr_a, out_wr_b;
  logic [31:0] fwd_a, fwd_b, drop_a, drop_b;

  always #5 clk = ~clk;

  as_oq_port_demux #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_OUTPUT_QUEUES(8),
                     .PORT_MASK(8'hFF), .IN_FIFO_DEPTH_BITS(4)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy_a), .out_data(out_data_a), .out_ctrl(out_ctrl_a), .out_wr(out_wr_a),
    .out_rdy(out_rdy), .pkt_fwd_cnt(fwd_a), .pkt_drop_cnt(drop_a));

  as_oq_port_demux #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_OUTPUT_QUEUES(8),
                     .PORT_MASK(8'h55), .IN_FIFO_DEPTH_BITS(4)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy_b), .out_data(out_data_b), .out_ctrl(out_ctrl_b), .out_wr(out_wr_b),
    .out_rdy(out_rdy), .pkt_fwd_cnt(fwd_b), .pkt_drop_cnt(drop_b));

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic [7:0]  l;
  } exp_t;

  typedef struct {
    logic [7:0] c0;
    logic [7:0] dst;
    int         nhdr;
    int         npay;
    logic [7:0] la;
    logic [7:0] lb;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   exp_fwd[2];
  int   exp_drop[2];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_rdy = 1'b0;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_lanes(input logic [7:0] c0, input logic [7:0] dst,
                                             input logic [7:0] mask);
    return (c0 == 8'hFF) ? (dst & mask) : 8'h00;
  endfunction

  task automatic chk_port(input int k, input logic [7:0] wr, input logic [63:0] d,
                          input logic [7:0] c);
    exp_t e;
    bit   have;
    if (wr != 8'h00) begin
      have = (k == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
      if (!have) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wr dut%0d: got out_wr %h, required none", k, wr);
      end else begin
        e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
        check($sformatf("lanes_dut%0d", k), 64'(wr), 64'(e.l));
        check($sformatf("data_dut%0d", k), d, e.d);
        check($sformatf("ctrl_dut%0d", k), 64'(c), 64'(e.c));
      end
      check($sformatf("wr_vs_rdy_dut%0d", k), 64'(wr & ~out_rdy), 64'd0);
    end
  endtask

  // Scoreboard monitor; also randomizes out_rdy when enabled
  task automatic monitor();
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        for (int i = 0; i < 8; i++) out_rdy[i] = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      if (reset) begin
        chk_port(0, out_wr_a, out_data_a, out_ctrl_a);
        chk_port(1, out_wr_b, out_data_b, out_ctrl_b);
      end
    end
  endtask

  task automatic put_word(input logic [63:0] d, input logic [7:0] c);
    int g = 0;
    while (!(in_rdy_a && in_rdy_b) && g < 2000) begin
      in_wr = 1'b0;
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL in_rdy_timeout: got in_rdy %b%b, required 11", in_rdy_a, in_rdy_b);
    end
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] c0, input logic [7:0] dst, input int nhdr,
                          input int npay, input logic [7:0] la, input logic [7:0] lb);
    logic [63:0] wd[$];
    logic [7:0]  wc[$];
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    d[23:16] = dst;
    wd.push_back(d); wc.push_back(c0);
    for (int i = 0; i < nhdr; i++) begin
      wd.push_back({$urandom(), $urandom()}); wc.push_back(8'($urandom_range(1, 255)));
    end
    for (int i = 0; i < npay; i++) begin
      wd.push_back({$urandom(), $urandom()}); wc.push_back(8'h00);
    end
    wd.push_back({$urandom(), $urandom()}); wc.push_back(8'($urandom_range(1, 255)));
    if (la != 8'h00) begin
      foreach (wd[i]) q_a.push_back('{d: wd[i], c: wc[i], l: la});
      exp_fwd[0]++;
    end else exp_drop[0]++;
    if (lb != 8'h00) begin
      foreach (wd[i]) q_b.push_back('{d: wd[i], c: wc[i], l: lb});
      exp_fwd[1]++;
    end else exp_drop[1]++;
    foreach (wd[i]) put_word(wd[i], wc[i]);
  endtask

  task automatic drain();
    int g = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && g < 3000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d/%0d words pending, required 0", q_a.size(), q_b.size());
    end
    repeat (24) @(posedge clk);
    #1;
    check("fwd_cnt_a", 64'(fwd_a), 64'(exp_fwd[0]));
    check("fwd_cnt_b", 64'(fwd_b), 64'(exp_fwd[1]));
    check("drop_cnt_a", 64'(drop_a), 64'(exp_drop[0]));
    check("drop_cnt_b", 64'(drop_b), 64'(exp_drop[1]));
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  c0, dst, ew;

    tbl[0] = '{8'hFF, 8'h00, 0, 3, 8'h00, 8'h00};
    tbl[1] = '{8'h10, 8'h04, 1, 2, 8'h00, 8'h00};
    tbl[2] = '{8'hFF, 8'hAA, 0, 4, 8'hAA, 8'h00};
    tbl[3] = '{8'hFF, 8'hAB, 1, 2, 8'hAB, 8'h01};
    tbl[4] = '{8'hFF, 8'h80, 2, 5, 8'h80, 8'h00};
    tbl[5] = '{8'hFF, 8'h41, 0, 1, 8'h41, 8'h41};
    tbl[6] = '{8'hFF, 8'hFF, 1, 3, 8'hFF, 8'h55};

    reset = 1'b0; in_data = '0; in_ctrl = '0; in_wr = 1'b0; out_rdy = 8'hFF;
    exp_fwd = '{0, 0}; exp_drop = '{0, 0};
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_a", 64'(out_wr_a), 64'd0);
    check("rst_wr_b", 64'(out_wr_b), 64'd0);
    check("rst_fwd_a", 64'(fwd_a), 64'd0);
    check("rst_drop_b", 64'(drop_b), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", 64'({in_rdy_a, in_rdy_b}), 64'd3);

    // Unicast: 10 words written on consecutive cycles once lanes are ready
    out_rdy = 8'h00;
    send_pkt(8'hFF, 8'h04, 0, 8, 8'h04, 8'h04);
    out_rdy = 8'hFF;
    for (int i = 0; i < 11; i++) begin
      ew = (i < 10) ? 8'h04 : 8'h00;
      @(negedge clk);
      check($sformatf("uni_wr_a[%0d]", i), 64'(out_wr_a), 64'(ew));
      check($sformatf("uni_wr_b[%0d]", i), 64'(out_wr_b), 64'(ew));
      @(posedge clk);
      #1;
    end
    drain();

    // Multicast with lane 2 stalled mid-payload and unselected lane 1 never ready
    out_rdy = 8'h00;
    send_pkt(8'hFF, 8'h05, 1, 5, 8'h05, 8'h05);
    for (int i = 0; i < 12; i++) begin
      out_rdy = (i >= 3 && i < 6) ? 8'hF9 : 8'hFD;
      ew = ((i >= 3 && i < 6) || i == 11) ? 8'h00 : 8'h05;
      @(negedge clk);
      check($sformatf("mc_wr_a[%0d]", i), 64'(out_wr_a), 64'(ew));
      check($sformatf("mc_wr_b[%0d]", i), 64'(out_wr_b), 64'(ew));
      @(posedge clk);
      #1;
    end
    out_rdy = 8'hFF;
    drain();

    // Back-to-back: packet 2 starts the cycle after EOP of packet 1
    out_rdy = 8'h00;
    send_pkt(8'hFF, 8'h01, 0, 1, 8'h01, 8'h01);
    send_pkt(8'hFF, 8'h10, 0, 1, 8'h10, 8'h10);
    out_rdy = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      ew = (i < 3) ? 8'h01 : ((i < 6) ? 8'h10 : 8'h00);
      @(negedge clk);
      check($sformatf("b2b_wr_a[%0d]", i), 64'(out_wr_a), 64'(ew));
      check($sformatf("b2b_wr_b[%0d]", i), 64'(out_wr_b), 64'(ew));
      @(posedge clk);
      #1;
    end
    drain();

    // Table: drops, non-IOQ first word, mask behaviour
    foreach (tbl[i]) begin
      send_pkt(tbl[i].c0, tbl[i].dst, tbl[i].nhdr, tbl[i].npay, tbl[i].la, tbl[i].lb);
      drain();
    end

    // Reset mid-payload
    d = {$urandom(), $urandom()}; d[23:16] = 8'h01;
    q_a.push_back('{d: d, c: 8'hFF, l: 8'h01}); q_b.push_back('{d: d, c: 8'hFF, l: 8'h01});
    put_word(d, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      d = {$urandom(), $urandom()};
      q_a.push_back('{d: d, c: 8'h00, l: 8'h01}); q_b.push_back('{d: d, c: 8'h00, l: 8'h01});
      put_word(d, 8'h00);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_a", 64'(out_wr_a), 64'd0);
    check("rst_mid_wr_b", 64'(out_wr_b), 64'd0);
    q_a.delete(); q_b.delete();
    exp_fwd = '{0, 0}; exp_drop = '{0, 0};
    @(posedge clk);
    #1;
    check("rst_mid_fwd_a", 64'(fwd_a), 64'd0);
    check("rst_mid_fwd_b", 64'(fwd_b), 64'd0);
    check("rst_mid_drop_a", 64'(drop_a), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_rdy", 64'({in_rdy_a, in_rdy_b}), 64'd3);
    send_pkt(8'hFF, 8'h02, 0, 3, 8'h02, 8'h00);
    drain();

    // Randomized packets and ready patterns against the reference model
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      c0  = ($urandom_range(7) == 0) ? 8'($urandom_range(1, 254)) : 8'hFF;
      dst = 8'($urandom());
      send_pkt(c0, dst, $urandom_range(0, 2), $urandom_range(1, 6),
               model_lanes(c0, dst, 8'hFF), model_lanes(c0, dst, 8'h55));
    end
    drain();
    rand_rdy = 1'b0;
    out_rdy  = 8'hFF;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
